// File: rtl/apb_rr_master_if.sv
// APB bus bundle between apb_rr_master and a single APB slave.
// Handshake: master raises PSELx (SETUP), then PENABLE (ACCESS) and holds PADDR/PWRITE/PWDATA; a transfer completes on the rising edge where PSELx & PENABLE & PREADY.
interface apb_rr_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] PADDR;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic              PSELx;
  logic              PENABLE;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PADDR, PWRITE, PWDATA, PSELx, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWRITE, PWDATA, PSELx, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_rr_master.sv
// Two-requester round-robin arbiter feeding one APB master port; all outputs registered.
// Define APB_RR_TIMEOUT_EN to terminate ACCESS after TIMEOUT_CYCLES cycles without PREADY.
module apb_rr_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_req0,
  input  logic              i_wr0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [DATA_W-1:0] i_wdata0,
  output logic              o_ack0,
  output logic [DATA_W-1:0] o_rdata0,
  output logic              o_err0,
  input  logic              i_req1,
  input  logic              i_wr1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_err1,
  apb_rr_master_if.master   apb,
  output logic [1:0]        o_state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]        state;
  logic              grant;
  logic              last_grant;
  logic              any_req;
  logic              win1;
  logic              timeout_hit;
  logic              acc_done;
  logic [DATA_W-1:0] acc_rdata;
  logic              acc_err;

  assign any_req = i_req0 | i_req1;
  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign win1    = i_req1 & (~i_req0 | ~last_grant);
  assign o_state = state;

`ifdef APB_RR_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] acc_cnt;

  // acc_cnt equals the number of ACCESS cycles already spent without PREADY.
  assign timeout_hit = (acc_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      acc_cnt <= '0;
    end else if (state == ST_SETUP) begin
      acc_cnt <= '0;
    end else if (state == ST_ACCESS && !apb.PREADY && !timeout_hit) begin
      acc_cnt <= acc_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // PREADY on the expiry cycle still counts as a normal completion.
  assign acc_done  = (state == ST_ACCESS) & (apb.PREADY | timeout_hit);
  assign acc_rdata = (apb.PREADY & ~apb.PWRITE) ? apb.PRDATA : '0;
  assign acc_err   = apb.PREADY ? apb.PSLVERR : 1'b1;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= ST_IDLE;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      apb.PADDR   <= '0;
      apb.PWRITE  <= 1'b0;
      apb.PWDATA  <= '0;
      apb.PSELx   <= 1'b0;
      apb.PENABLE <= 1'b0;
      o_ack0      <= 1'b0;
      o_rdata0    <= '0;
      o_err0      <= 1'b0;
      o_ack1      <= 1'b0;
      o_rdata1    <= '0;
      o_err1      <= 1'b0;
    end else begin
      o_ack0 <= 1'b0;
      o_ack1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            apb.PADDR   <= win1 ? i_addr1  : i_addr0;
            apb.PWRITE  <= win1 ? i_wr1    : i_wr0;
            apb.PWDATA  <= win1 ? i_wdata1 : i_wdata0;
            apb.PSELx   <= 1'b1;
            apb.PENABLE <= 1'b0;
            grant       <= win1;
            last_grant  <= win1;
            state       <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          apb.PENABLE <= 1'b1;
          state       <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (acc_done) begin
            apb.PSELx   <= 1'b0;
            apb.PENABLE <= 1'b0;
            state       <= ST_DONE;
            if (grant) begin
              o_ack1   <= 1'b1;
              o_rdata1 <= acc_rdata;
              o_err1   <= acc_err;
            end else begin
              o_ack0   <= 1'b1;
              o_rdata0 <= acc_rdata;
              o_err0   <= acc_err;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Round-robin arbiter plus APB master. Lets two requesters share one APB slave port, e.g. the 8-word APB register-file slave.
- Each requester uses a simple level-held req/ack interface.
- The block sequences APB SETUP and ACCESS phases, waits for PREADY, then returns read data and error status to the granted requester.
- Sits between internal bus clients and the APB slave.

Parameters:
- ADDR_W, 32, width of PADDR and requester addresses.
- DATA_W, 32, width of PWDATA/PRDATA and requester data.
- TIMEOUT_CYCLES, 16, ACCESS-phase cycles before forced termination. Used only with APB_RR_TIMEOUT_EN.

Ports:
- i_clk  in  1  APB clock, all logic on rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_req0  in  1  requester 0 request. Held high until o_ack0.
- i_wr0  in  1  requester 0 direction: 1=write, 0=read.
- i_addr0  in  ADDR_W  requester 0 address.
- i_wdata0  in  DATA_W  requester 0 write data.
- o_ack0  out  1  one-cycle completion pulse to requester 0.
- o_rdata0  out  DATA_W  read data to requester 0, valid with o_ack0.
- o_err0  out  1  slave error to requester 0, valid with o_ack0.
- i_req1, i_wr1, i_addr1, i_wdata1, o_ack1, o_rdata1, o_err1: same as requester 0, for requester 1.
- PADDR  out  ADDR_W  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_W  APB write data.
- PSELx  out  1  APB select.
- PENABLE  out  1  APB enable.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- All outputs are registered.
- Reset (async assert, sync release): state=IDLE; PSELx=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0; o_ack*=0, o_rdata*=0, o_err*=0; last_grant=1, so requester 0 wins the first tie.
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If any request is pending, pick a winner. Only one requesting: grant it. Both requesting: grant the one that is not last_grant.
  - Register the winner's addr/wr/wdata onto PADDR/PWRITE/PWDATA. Set PSELx=1, PENABLE=0, grant=winner, last_grant=winner. Go to SETUP.
  - No request pending: stay in IDLE.
- SETUP: exactly one cycle. Set PENABLE=1. Go to ACCESS.
- ACCESS:
  - Hold PSELx, PENABLE, PADDR, PWRITE, PWDATA stable.
  - PREADY=1 sampled: capture PRDATA (reads only; writes return o_rdata=0) and PSLVERR into the granted requester's o_rdata/o_err. Pulse the granted o_ack for one cycle. Drop PSELx and PENABLE. Go to DONE.
- DONE: one cycle. The requester may deassert or re-present its request. Go to IDLE. No new grant is issued in DONE.
- Latency: request seen in IDLE at cycle N; SETUP at N+1; ACCESS at N+2. Zero-wait slave: o_ack at N+3. Minimum 4 cycles between back-to-back transfers.
- Requests are not sampled outside IDLE. A request that drops before grant is ignored.
- o_rdata/o_err of a requester hold their value until that requester's next ack.
- Never both acks in the same cycle. Never an ack without a preceding grant.
- Reset mid-transfer: the bus returns immediately to idle (PSELx=PENABLE=0). No ack is issued and arbitration state is lost.

Optional Feature:
- Macro APB_RR_TIMEOUT_EN.
- Defined: a counter starts on ACCESS entry. If PREADY has not been seen after TIMEOUT_CYCLES ACCESS cycles, terminate the transfer: drop PSELx/PENABLE, pulse the granted ack with o_err=1 and o_rdata=0, go to DONE. PREADY arriving on the same cycle as expiry wins: normal completion.
- Not defined: ACCESS waits indefinitely for PREADY. No counter logic.

Test Plan:
- Requester 0 writes addr 3, data 0xDEADBEEF; slave PREADY=1 in the first ACCESS cycle -> PSELx at N+1, PENABLE at N+2, o_ack0 at N+3, o_err0=0, PWDATA=0xDEADBEEF throughout.
- Requester 1 reads addr 3 after the above; slave returns 0xDEADBEEF with 2 wait states -> o_ack1 at N+5, o_rdata1=0xDEADBEEF.
- Both requesters held high continuously from reset for 4 transfers -> grant order 0,1,0,1; acks 4 cycles apart.
- Read of addr 9 with PSLVERR=1 at PREADY -> o_err0=1 with o_ack0; next valid read -> o_err0=0.
- Assert i_reset_n=0 during ACCESS -> PSELx and PENABLE go 0 asynchronously, no ack; after release requester 0 wins a tie.
- With APB_RR_TIMEOUT_EN and PREADY tied 0 -> ack with o_err=1 after 16 ACCESS cycles and PSELx dropped. Without the macro -> no ack for 100 cycles.
